// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared constants and entry type for the IF/ID pipeline register
package if_id_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_ILEN   = 32;
  localparam int DEF_META_W = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int META_PRED_TAKEN  = 0;
  localparam int META_FETCH_FAULT = 1;

  typedef struct packed {
    logic                  valid;
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_ILEN-1:0]   instr;
    logic [DEF_META_W-1:0] meta;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_slot.sv
// rtl/if_id_slot.sv - single IF/ID entry register with load, clear and sync reset
// Clear wins over load and keeps pc, so a squashed stage still shows its last PC.
module if_id_slot #(
  parameter int XLEN   = if_id_pkg::DEF_XLEN,
  parameter int ILEN   = if_id_pkg::DEF_ILEN,
  parameter int META_W = if_id_pkg::DEF_META_W,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(if_id_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [XLEN-1:0]   d_pc,
  input  logic [ILEN-1:0]   d_instr,
  input  logic [META_W-1:0] d_meta,
  output logic              valid,
  output logic [XLEN-1:0]   pc,
  output logic [ILEN-1:0]   instr,
  output logic [META_W-1:0] meta
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
      meta  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      meta  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      instr <= d_instr;
      meta  <= d_meta;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with stall, flush and stall counter
// Define IF_ID_SKID_EN to add the skid slot and register in_ready.
module if_id_pipe_reg #(
  parameter int XLEN   = if_id_pkg::DEF_XLEN,
  parameter int ILEN   = if_id_pkg::DEF_ILEN,
  parameter int META_W = if_id_pkg::DEF_META_W,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(if_id_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [ILEN-1:0]   in_instr,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_instr,
  output logic [META_W-1:0] out_meta,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt
);

  logic              accept;
  logic              m_drain;
  logic              m_load;
  logic              m_clear;
  logic              m_valid;
  logic [XLEN-1:0]   m_d_pc;
  logic [ILEN-1:0]   m_d_instr;
  logic [META_W-1:0] m_d_meta;
  logic [31:0]       stall_cnt_q;

  assign accept  = in_valid & in_ready;
  assign m_drain = m_valid & out_ready;

`ifdef IF_ID_SKID_EN
  logic              s_valid;
  logic              s_load;
  logic              s_clear;
  logic              m_free;
  logic [XLEN-1:0]   s_pc;
  logic [ILEN-1:0]   s_instr;
  logic [META_W-1:0] s_meta;

  // in_ready depends only on the S flop, never on out_ready
  assign in_ready = !s_valid | !rst_n;
  assign m_free   = !m_valid | out_ready;

  assign m_load  = !flush & (s_valid ? m_drain : (accept & m_free));
  assign m_clear = flush | (m_drain & !m_load);
  assign s_load  = !flush & accept & (s_valid ? m_drain : !m_free);
  assign s_clear = flush | (s_valid & m_drain & !s_load);

  assign m_d_pc    = s_valid ? s_pc    : in_pc;
  assign m_d_instr = s_valid ? s_instr : in_instr;
  assign m_d_meta  = s_valid ? s_meta  : in_meta;

  if_id_slot #(
    .XLEN(XLEN), .ILEN(ILEN), .META_W(META_W), .NOP_INSTR(NOP_INSTR)
  ) u_skid (
    .clk(clk), .rst_n(rst_n), .load(s_load), .clear(s_clear),
    .d_pc(in_pc), .d_instr(in_instr), .d_meta(in_meta),
    .valid(s_valid), .pc(s_pc), .instr(s_instr), .meta(s_meta)
  );

  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
  assign in_ready  = !m_valid | out_ready | !rst_n;
  assign m_load    = accept & !flush;
  assign m_clear   = flush | (m_drain & !accept);
  assign m_d_pc    = in_pc;
  assign m_d_instr = in_instr;
  assign m_d_meta  = in_meta;
  assign occupancy = {1'b0, m_valid};
`endif

  if_id_slot #(
    .XLEN(XLEN), .ILEN(ILEN), .META_W(META_W), .NOP_INSTR(NOP_INSTR)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .load(m_load), .clear(m_clear),
    .d_pc(m_d_pc), .d_instr(m_d_instr), .d_meta(m_d_meta),
    .valid(m_valid), .pc(out_pc), .instr(out_instr), .meta(out_meta)
  );

  assign out_valid = m_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (m_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, stall back-pressure, synchronous flush with NOP insertion, and an optional skid slot. It sits between the fetch stage and the decoder. It carries PC, instruction and a fetch sideband (prediction and fault bits). The decoder can stall fetch, and the branch/trap logic can squash wrong-path instructions, without either of them touching the fetch datapath.

## Interface
Parameters:
- XLEN, 32, PC width
- ILEN, 32, instruction width
- META_W, 4, fetch sideband width (bit0 predicted-taken, bit1 fetch fault, rest reserved)
- NOP_INSTR, 32'h0000_0013, instruction driven when the stage holds no valid beat

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage accepts the beat this cycle
- in_pc  in  XLEN  fetch PC
- in_instr  in  ILEN  fetched instruction
- in_meta  in  META_W  fetch sideband
- out_valid  out  1  decoder-side beat valid
- out_ready  in  1  decoder consumes the beat; low means stall
- out_pc  out  XLEN  registered PC
- out_instr  out  ILEN  registered instruction; NOP_INSTR when out_valid=0
- out_meta  out  META_W  registered sideband; 0 when out_valid=0
- flush  in  1  squash all held and incoming beats
- occupancy  out  2  entries held (0..2; max 1 without skid)
- stall_cnt  out  32  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Handshakes:
  - A beat transfers in when in_valid & in_ready.
  - A beat transfers out when out_valid & out_ready.
- Main register (M) drives the out_* ports.
- Without skid:
  - in_ready = !M.valid | out_ready (combinational from out_ready).
  - Accept loads M. A simultaneous drain and accept replaces M in place.
- With skid (S):
  - in_ready = !S.valid, registered.
  - Accept while M is empty, or while M drains, loads M.
  - Accept while M is held (valid, out_ready=0) loads S.
  - When M drains and S is valid, S moves to M and S empties. If that same cycle also has an accept, the new beat loads S.
- Flush:
  - Flush has priority over all handshakes, below rst_n.
  - Next cycle M.valid=0 and S.valid=0, out_instr=NOP_INSTR, out_meta=0, and out_pc holds its last value.
  - A beat offered during flush completes its handshake (in_ready is not altered) and is discarded.
  - A drain in the flush cycle still counts as delivered; the decoder owns suppressing it.
- stall_cnt increments every cycle with out_valid & !out_ready and saturates at 32'hFFFF_FFFF. It is not cleared by flush.
- Outputs never present X: invalid entries drive NOP_INSTR and 0.

## Timing
- Reset (rst_n=0 at an edge) forces the following on the next cycle:
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_meta=0
  - occupancy=0, stall_cnt=0, S cleared
  - in_ready=1
- Reset mid-transfer drops all beats. in_ready reads 1 during reset.
- Latency is 1 cycle: a beat accepted at edge N is on out_* after edge N.
- Throughput is 1 beat/cycle with out_ready held high, in both modes.
- Skid mode:
  - in_ready falls one cycle after S fills and rises one cycle after S empties.
  - No beat is lost while in_ready is stale, because S absorbs the in-flight beat.
- Flush plus a beat on the same edge: the result is empty, not the new beat. The first post-flush beat is accepted on the following cycle.

## Configuration
- IF_ID_SKID_EN defined:
  - The skid slot S is instantiated and in_ready is a flop output, which breaks the out_ready→in_ready combinational path.
  - occupancy reaches 2.
- IF_ID_SKID_EN undefined:
  - There is no S, and in_ready is combinational from out_ready.
  - occupancy ≤ 1, and the stage costs one register set.

## Structure
- Package if_id_pkg holds:
  - NOP_INSTR, and the default XLEN, ILEN and META_W values
  - the META bit-index constants (META_PRED_TAKEN=0, META_FETCH_FAULT=1)
  - a packed struct if_id_entry_t {valid, pc, instr, meta}
- One sub-module, if_id_slot: a single entry register with load, clear and synchronous reset. It is instantiated once for M and, under IF_ID_SKID_EN, once for S.

## Test plan
- Reset check: rst_n=0 for 2 cycles with in_valid=1 and in_pc=32'h100 → out_valid=0, out_instr=32'h13, out_pc=0, occupancy=0, stall_cnt=0.
- Streaming: in_valid=1 with pc 0x0, 0x4, 0x8 and instr 0xA, 0xB, 0xC on consecutive cycles, out_ready=1 → identical sequence on out_* with 1-cycle latency and no bubbles.
- Stall, skid built: M holds pc 0x4, out_ready=0 for 3 cycles, in_valid=1 with pc 0x8 → S captures 0x8 and in_ready falls one cycle later. With out_ready=1, 0x4 then 0x8 drain in order, and stall_cnt=3.
- Stall, skid not built: the same stimulus → in_ready=0 in the same cycle out_ready=0 with M valid, pc 0x8 is held at the source, and occupancy never exceeds 1.
- Flush: M=0x10, S=0x14, flush=1 with in_valid=1 and pc 0x18 → next cycle out_valid=0, out_instr=0x13, occupancy=0. pc 0x18 is discarded, and a new beat with pc 0x40 is accepted on the following cycle.
- Saturation: preload stall_cnt near max via long stall (or force) → it stops at 32'hFFFF_FFFF and does not wrap.
